pi_dpi_capture: RTL and testbench
=================================

# pi_dpi_capture

Samples the Raspberry Pi DPI video bus in the 81 MHz domain, using the 0–5 pixel-clock phase count from the pixel clock PLL to take exactly one sample per 13.5 MHz pixel at a programmable phase. Decodes vsync/hsync/data-enable into a pixel stream with X/Y coordinates and frame/line markers for the downstream frame store and overlay logic. Sits directly downstream of the pixel clock PLL and shares its 81 MHz clock and phase counter.

## Interface
- DATA_W, 12: DPI pixel data width.
- SYNC_ACTIVE_LOW, 0: 1 = vsync/hsync pins active-low; de is always active-high.
- H_ACTIVE, 720: expected active pixels per line (line statistics only).
- clk  in  1  81 MHz pixel clock x6; sole clock.
- reset  in  1  synchronous, active-high reset.
- clk_phase  in  3  phase count 0..5, advancing by one per clk.
- sample_phase  in  3  phase on which the synchronised bus is sampled; quasi-static.
- dpi_data  in  DATA_W  asynchronous pixel data.
- dpi_vsync, dpi_hsync, dpi_de  in  1 each  asynchronous syncs/enable.
- pixel_data  out  DATA_W  captured pixel.
- pixel_valid  out  1  one-clk strobe, pixel_data/pixel_x/pixel_y valid.
- pixel_x, pixel_y  out  10 each  coordinates of the current pixel.
- line_start  out  1  with pixel_valid on first pixel of a line.
- frame_start  out  1  one-clk pulse on detected vsync assertion.
- overflow  out  1  sticky: X or Y counter saturated.
- line_length  out  11  pixel count of last completed line.
- line_mismatch  out  1  one-clk pulse when completed line length ≠ H_ACTIVE.

## Operation
- All five dpi inputs pass through a two-flop synchroniser (s1, s2) every clk.
- Sample strobe = (clk_phase == sample_phase). sample_phase 6 or 7 never matches: no samples, FSM frozen.
- At each strobe the s2 values are latched as "current sample"; edges are current vs previous sample (per strobe, not per clk). Sync polarity normalised by SYNC_ACTIVE_LOW first.
- FSM states: SEEK, BLANK, ACTIVE. Reset value SEEK.
- SEEK: ignore everything until vsync rising edge -> frame_start, y=0, -> BLANK.
- BLANK: de rising -> emit pixel with x=0, line_start=1, -> ACTIVE.
- ACTIVE: de high -> emit pixel, x+1. de falling -> line complete: y+1, line_length updated, -> BLANK.
- vsync rising edge in BLANK or ACTIVE: frame_start, y=0, x=0, -> BLANK; wins over any de event on that strobe (pixel discarded, no y increment).
- hsync is synchronised but only de delimits lines; hsync is ignored.
- x/y saturate at 1023; saturation sets overflow, cleared only by reset.
- Line length counter is 11 bits, saturates at 2047.

## Timing
- Reset values: pixel_data 0, pixel_valid 0, pixel_x 0, pixel_y 0, line_start 0, frame_start 0, overflow 0, line_length 0, line_mismatch 0.
- Pin to s2: 2 clks. Strobe cycle latches s2; pixel_valid, line_start, frame_start, line_mismatch assert on the following clk edge for exactly one clk.
- Strobes are 6 clks apart; pixel_valid at most once per 6 clks.
- Outputs other than strobes hold between pixels.
- Reset asserted mid-line: next clk all outputs at reset values, FSM SEEK; partial line discarded.
- Change of sample_phase mid-frame: legal; may drop or duplicate one sample, no other effect.

## Configuration
- PI_DPI_CAPTURE_LINE_STATS_EN defined: line_length and line_mismatch operate as above.
- Undefined: line length counter omitted; line_length tied 0, line_mismatch tied 0; all other behaviour identical.

## Test plan
- Reset then 3 lines of 720 pixels with sample_phase=2 -> 2160 pixel_valid pulses, all asserted 1 clk after clk_phase==2, x 0..719, y 0..2.
- Data ramp 0x000.. per pixel, sweep sample_phase 0..5 -> captured values unchanged for stable 6-clk data; sample_phase=7 -> zero pixel_valid.
- De asserted before any vsync -> no pixel_valid; first vsync -> frame_start, next line y=0.
- Vsync rising on same strobe as de rising -> frame_start, no pixel_valid that strobe, next pixel x=1 is not emitted; line begins on next de rising.
- Line of 1100 pixels -> pixel_x holds 1023, overflow=1; with _EN line_length=1100, line_mismatch pulse; without, both 0.
- Reset asserted mid-line at x=300 -> all outputs 0 next clk; no pixel_valid until next vsync.

Source files
------------

// File: rtl/pi_dpi_capture_if.sv
// -----------------------------------------------------------------------------
// pi_dpi_capture_if
//   Pixel stream produced by pi_dpi_capture for the frame store and overlay
//   logic. Carries no clock: all members are synchronous to the 81 MHz clk
//   that the producer and the consumers share.
//
//   Members
//     pixel_data    DATA_W  captured pixel
//     pixel_valid   1       one-clk strobe, data/x/y valid
//     pixel_x       10      x coordinate of the current pixel (saturates 1023)
//     pixel_y       10      y coordinate of the current pixel (saturates 1023)
//     line_start    1       with pixel_valid on the first pixel of a line
//     frame_start   1       one-clk pulse on detected vsync assertion
//     overflow      1       sticky, X or Y counter saturated
//     line_length   11      pixel count of the last completed line
//     line_mismatch 1       one-clk pulse, completed line length != H_ACTIVE
//
//   Modports
//     master  producer (pi_dpi_capture)
//     slave   consumer
// -----------------------------------------------------------------------------
interface pi_dpi_capture_if #(
   parameter int DATA_W = 12
);
   logic [DATA_W-1:0] pixel_data;
   logic              pixel_valid;
   logic [9:0]        pixel_x;
   logic [9:0]        pixel_y;
   logic              line_start;
   logic              frame_start;
   logic              overflow;
   logic [10:0]       line_length;
   logic              line_mismatch;

   modport master (
      output pixel_data, pixel_valid, pixel_x, pixel_y, line_start,
             frame_start, overflow, line_length, line_mismatch
   );

   modport slave (
      input  pixel_data, pixel_valid, pixel_x, pixel_y, line_start,
             frame_start, overflow, line_length, line_mismatch
   );
endinterface

// File: rtl/pi_dpi_capture.sv
// -----------------------------------------------------------------------------
// pi_dpi_capture
//   Samples the Raspberry Pi DPI bus in the 81 MHz domain (6x the 13.5 MHz
//   pixel clock). All DPI pins pass through a two-flop synchroniser; the
//   synchronised bus is sampled once per pixel when the PLL phase count
//   matches sample_phase. Successive samples are compared to find vsync and
//   de edges, which drive a SEEK/BLANK/ACTIVE state machine producing a pixel
//   stream with X/Y coordinates and frame/line markers.
//
//   Parameters
//     DATA_W           DPI pixel data width
//     SYNC_ACTIVE_LOW  1 = vsync/hsync pins are active-low (de always high)
//     H_ACTIVE         expected active pixels per line (line statistics only)
//
//   Ports
//     clk           in   81 MHz clock, sole clock
//     reset         in   synchronous, active-high
//     clk_phase     in   3   PLL phase count 0..5, +1 per clk
//     sample_phase  in   3   phase on which the bus is sampled (6/7 = never)
//     dpi_data      in   DATA_W  asynchronous pixel data
//     dpi_vsync     in   asynchronous vertical sync
//     dpi_hsync     in   asynchronous horizontal sync (synchronised, unused)
//     dpi_de        in   asynchronous data enable
//     pix           pi_dpi_capture_if.master  output pixel stream
//
//   Build option
//     PI_DPI_CAPTURE_LINE_STATS_EN  defined: line_length/line_mismatch are
//     produced; undefined: the line counter is omitted and both are tied 0.
// -----------------------------------------------------------------------------
module pi_dpi_capture #(
   parameter int DATA_W          = 12,
   parameter bit SYNC_ACTIVE_LOW = 1'b0,
   parameter int H_ACTIVE        = 720
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [2:0]        clk_phase,
   input  logic [2:0]        sample_phase,
   input  logic [DATA_W-1:0] dpi_data,
   input  logic              dpi_vsync,
   input  logic              dpi_hsync,
   input  logic              dpi_de,
   pi_dpi_capture_if.master  pix
);

   localparam logic [1:0] S_SEEK   = 2'd0;
   localparam logic [1:0] S_BLANK  = 2'd1;
   localparam logic [1:0] S_ACTIVE = 2'd2;

   // ---------------------------------------------------------------- sync ---
   logic [DATA_W-1:0] data_s1, data_s2;
   logic [2:0]        ctl_s1, ctl_s2;      // {vsync, hsync, de}

   // NOTE: the synchroniser carries no state worth resetting; whatever it
   // holds is flushed by the pins within two clocks, so it has no reset term.
   always_ff @(posedge clk) begin
      data_s1 <= dpi_data;
      data_s2 <= data_s1;
      ctl_s1  <= {dpi_vsync, dpi_hsync, dpi_de};
      ctl_s2  <= ctl_s1;
   end

   // Lines are delimited by de alone; hsync is carried through the
   // synchroniser only so the pin timing matches the rest of the bus.
   logic unused_hsync;
   assign unused_hsync = ctl_s2[1];

   // -------------------------------------------------------- sample/edges ---
   logic strobe;
   logic vs_now, de_now;
   logic cur_vs, cur_de;                   // sample taken at previous strobe
   logic vs_rise, de_rise;

   assign strobe  = (clk_phase == sample_phase);
   assign vs_now  = ctl_s2[2] ^ SYNC_ACTIVE_LOW;
   assign de_now  = ctl_s2[0];
   assign vs_rise = vs_now & ~cur_vs;
   assign de_rise = de_now & ~cur_de;

   // ----------------------------------------------------------------- FSM ---
   logic [1:0] state, state_nxt;
   logic       go_frame, line_begin, line_pixel, line_end;

   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case leaves it unassigned and no latch is inferred.
      state_nxt  = state;
      go_frame   = 1'b0;
      line_begin = 1'b0;
      line_pixel = 1'b0;
      line_end   = 1'b0;
      if (strobe) begin
         if (vs_rise) begin
            // Frame start overrides any de event on the same sample.
            go_frame  = 1'b1;
            state_nxt = S_BLANK;
         end else begin
            case (state)
               S_SEEK: ;
               S_BLANK:
                  if (de_rise) begin
                     line_begin = 1'b1;
                     state_nxt  = S_ACTIVE;
                  end
               S_ACTIVE:
                  if (de_now) begin
                     line_pixel = 1'b1;
                  end else begin
                     line_end  = 1'b1;
                     state_nxt = S_BLANK;
                  end
               default: state_nxt = S_SEEK;
            endcase
         end
      end
   end

   // ------------------------------------------------------ pixel datapath ---
   // x_cnt/y_cnt are coordinates of the next pixel. They stop at 1024, which
   // marks "past the last representable coordinate": emitted coordinates
   // clamp to 1023 and emitting there raises overflow.
   logic [10:0]       x_cnt, y_cnt;
   logic [DATA_W-1:0] pixel_data_r;
   logic [9:0]        pixel_x_r, pixel_y_r;
   logic              pixel_valid_r, line_start_r, frame_start_r, overflow_r;
   logic              emit;

   assign emit = line_begin | line_pixel;

   // NOTE: sequential state uses non-blocking assignments only, so every
   // right-hand side below reads the value from before this clock edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_SEEK;
         cur_vs        <= 1'b0;
         cur_de        <= 1'b0;
         x_cnt         <= '0;
         y_cnt         <= '0;
         pixel_data_r  <= '0;
         pixel_x_r     <= '0;
         pixel_y_r     <= '0;
         pixel_valid_r <= 1'b0;
         line_start_r  <= 1'b0;
         frame_start_r <= 1'b0;
         overflow_r    <= 1'b0;
      end else begin
         state         <= state_nxt;
         pixel_valid_r <= emit;
         line_start_r  <= line_begin;
         frame_start_r <= go_frame;

         if (strobe) begin
            cur_vs <= vs_now;
            cur_de <= de_now;
         end

         if (go_frame) begin
            x_cnt <= '0;
            y_cnt <= '0;
         end

         // x_cnt is already 0 on line_begin: every entry to BLANK clears it.
         if (emit) begin
            pixel_data_r <= data_s2;
            pixel_x_r    <= x_cnt[10] ? 10'h3ff : x_cnt[9:0];
            pixel_y_r    <= y_cnt[10] ? 10'h3ff : y_cnt[9:0];
            if (x_cnt[10] | y_cnt[10]) overflow_r <= 1'b1;
            if (!x_cnt[10])            x_cnt      <= x_cnt + 11'd1;
         end

         if (line_end) begin
            x_cnt <= '0;
            if (!y_cnt[10]) y_cnt <= y_cnt + 11'd1;
         end
      end
   end

   assign pix.pixel_data  = pixel_data_r;
   assign pix.pixel_valid = pixel_valid_r;
   assign pix.pixel_x     = pixel_x_r;
   assign pix.pixel_y     = pixel_y_r;
   assign pix.line_start  = line_start_r;
   assign pix.frame_start = frame_start_r;
   assign pix.overflow    = overflow_r;

   // ------------------------------------------------------ line statistics ---
`ifdef PI_DPI_CAPTURE_LINE_STATS_EN
   logic [10:0] line_len, line_length_r;
   logic        line_mismatch_r;

   always_ff @(posedge clk) begin
      if (reset) begin
         line_len        <= '0;
         line_length_r   <= '0;
         line_mismatch_r <= 1'b0;
      end else begin
         line_mismatch_r <= 1'b0;
         if (line_begin) begin
            line_len <= 11'd1;
         end else if (line_pixel && line_len != 11'h7ff) begin
            line_len <= line_len + 11'd1;
         end
         // A line cut short by vsync never reaches line_end and is not reported.
         if (line_end) begin
            line_length_r   <= line_len;
            line_mismatch_r <= (line_len != 11'(H_ACTIVE));
         end
      end
   end

   assign pix.line_length   = line_length_r;
   assign pix.line_mismatch = line_mismatch_r;
`else
   logic [10:0] unused_h_active;
   assign unused_h_active   = 11'(H_ACTIVE);
   assign pix.line_length   = '0;
   assign pix.line_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_pi_dpi_capture.sv
// -----------------------------------------------------------------------------
// tb_pi_dpi_capture
//   Directed bench for pi_dpi_capture. The stimulus drives clk_phase and the
//   DPI bus one pixel (6 clks) at a time, with bus changes aligned to phase 0.
//   Every pixel expected on the output is queued with its hand-derived x/y/
//   data; a monitor pops and compares on each pixel_valid and counts markers.
// -----------------------------------------------------------------------------
module tb_pi_dpi_capture;

   localparam int DATA_W = 12;

   logic              clk = 1'b0;
   logic              reset;
   logic [2:0]        clk_phase;
   logic [2:0]        sample_phase;
   logic [DATA_W-1:0] dpi_data;
   logic              dpi_vsync, dpi_hsync, dpi_de;

   pi_dpi_capture_if #(.DATA_W(DATA_W)) pix_if ();

   pi_dpi_capture #(
      .DATA_W(DATA_W),
      .SYNC_ACTIVE_LOW(1'b0),
      .H_ACTIVE(720)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clk_phase(clk_phase),
      .sample_phase(sample_phase),
      .dpi_data(dpi_data),
      .dpi_vsync(dpi_vsync),
      .dpi_hsync(dpi_hsync),
      .dpi_de(dpi_de),
      .pix(pix_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int x;
      int y;
      int data;
      bit ls;
   } pix_t;

   pix_t exp_q[$];
   pix_t e;
   int   n_pv = 0, n_fs = 0, n_ls = 0, n_lm = 0, n_phase_bad = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Monitor: samples 1 ns after each rising edge.
   always @(posedge clk) begin
      #1;
      if (pix_if.pixel_valid === 1'b1) begin
         n_pv++;
         if (clk_phase !== sample_phase) n_phase_bad++;
         if (exp_q.size() == 0) begin
            check("unexpected_pixel", 32'(pix_if.pixel_x), 32'hffff_ffff);
         end else begin
            e = exp_q.pop_front();
            check("pixel_x",    32'(pix_if.pixel_x),    32'(e.x));
            check("pixel_y",    32'(pix_if.pixel_y),    32'(e.y));
            check("pixel_data", 32'(pix_if.pixel_data), 32'(e.data));
            check("line_start", 32'(pix_if.line_start), 32'(e.ls));
         end
      end
      if (pix_if.frame_start === 1'b1)   n_fs++;
      if (pix_if.line_start === 1'b1)    n_ls++;
      if (pix_if.line_mismatch === 1'b1) n_lm++;
   end

   task automatic tick();
      @(negedge clk);
      clk_phase = (clk_phase == 3'd5) ? 3'd0 : clk_phase + 3'd1;
   endtask

   // One pixel period: bus changes together with the wrap to phase 0.
   task automatic pix(input bit v, input bit d, input logic [DATA_W-1:0] val);
      tick();
      dpi_vsync = v;
      dpi_hsync = ~d;
      dpi_de    = d;
      dpi_data  = val;
      repeat (5) tick();
   endtask

   task automatic vsync_pulse();
      pix(1'b1, 1'b0, '0);
      pix(1'b1, 1'b0, '0);
      pix(1'b0, 1'b0, '0);
      pix(1'b0, 1'b0, '0);
   endtask

   // n pixels of ramp data from base; queue them when they should appear.
   task automatic line(input int n, input int y, input int base, input bit expect_out);
      for (int i = 0; i < n; i++) begin
         if (expect_out)
            exp_q.push_back('{(i > 1023) ? 1023 : i, y, (base + i) & 'hfff, (i == 0)});
         pix(1'b0, 1'b1, DATA_W'(base + i));
      end
      pix(1'b0, 1'b0, '0);
      pix(1'b0, 1'b0, '0);
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_data"},   32'(pix_if.pixel_data),    32'd0);
      check({tag, "_valid"},  32'(pix_if.pixel_valid),   32'd0);
      check({tag, "_x"},      32'(pix_if.pixel_x),       32'd0);
      check({tag, "_y"},      32'(pix_if.pixel_y),       32'd0);
      check({tag, "_ls"},     32'(pix_if.line_start),    32'd0);
      check({tag, "_fs"},     32'(pix_if.frame_start),   32'd0);
      check({tag, "_ovf"},    32'(pix_if.overflow),      32'd0);
      check({tag, "_len"},    32'(pix_if.line_length),   32'd0);
      check({tag, "_mism"},   32'(pix_if.line_mismatch), 32'd0);
   endtask

   int pv0, fs0, ls0, lm0;

   initial begin
      reset        = 1'b1;
      clk_phase    = 3'd5;
      sample_phase = 3'd2;
      dpi_data     = '0;
      dpi_vsync    = 1'b0;
      dpi_hsync    = 1'b1;
      dpi_de       = 1'b0;

      // ---- reset values
      pix(1'b0, 1'b0, '0);
      pix(1'b0, 1'b0, '0);
      check_reset_values("reset");
      reset = 1'b0;

      // ---- three 720-pixel lines at sample_phase 2
      pv0 = n_pv; fs0 = n_fs; ls0 = n_ls; lm0 = n_lm;
      pix(1'b0, 1'b0, '0);
      vsync_pulse();
      line(720, 0, 0,    1'b1);
      line(720, 1, 720,  1'b1);
      line(720, 2, 1440, 1'b1);
      check("t1_pv_count",  32'(n_pv - pv0), 32'd2160);
      check("t1_fs_count",  32'(n_fs - fs0), 32'd1);
      check("t1_ls_count",  32'(n_ls - ls0), 32'd3);
      check("t1_queue",     32'(exp_q.size()), 32'd0);
      check("t1_hold_x",    32'(pix_if.pixel_x), 32'd719);
      check("t1_hold_y",    32'(pix_if.pixel_y), 32'd2);
      check("t1_overflow",  32'(pix_if.overflow), 32'd0);
      check("t1_mismatch",  32'(n_lm - lm0), 32'd0);
`ifdef PI_DPI_CAPTURE_LINE_STATS_EN
      check("t1_line_len",  32'(pix_if.line_length), 32'd720);
`else
      check("t1_line_len",  32'(pix_if.line_length), 32'd0);
`endif

      // ---- sample_phase sweep, ramp data must be captured unchanged
      for (int p = 0; p < 6; p++) begin
         sample_phase = 3'(p);
         pix(1'b0, 1'b0, '0);
         vsync_pulse();
         pv0 = n_pv;
         line(8, 0, 16 * p + 3, 1'b1);
         check($sformatf("t2_pv_count_ph%0d", p), 32'(n_pv - pv0), 32'd8);
      end
      check("t2_queue", 32'(exp_q.size()), 32'd0);

      // sample_phase 7 never strobes
      sample_phase = 3'd7;
      pv0 = n_pv; fs0 = n_fs;
      vsync_pulse();
      line(8, 0, 0, 1'b0);
      check("t2_ph7_pv", 32'(n_pv - pv0), 32'd0);
      check("t2_ph7_fs", 32'(n_fs - fs0), 32'd0);
      sample_phase = 3'd2;
      pix(1'b0, 1'b0, '0);

      // ---- de before any vsync is ignored
      reset = 1'b1;
      pix(1'b0, 1'b0, '0);
      reset = 1'b0;
      pv0 = n_pv; fs0 = n_fs;
      line(10, 0, 0, 1'b0);
      check("t3_no_pv", 32'(n_pv - pv0), 32'd0);
      vsync_pulse();
      check("t3_fs", 32'(n_fs - fs0), 32'd1);
      line(5, 0, 100, 1'b1);
      check("t3_pv", 32'(n_pv - pv0), 32'd5);

      // ---- vsync rising on the same sample as de rising
      pv0 = n_pv; fs0 = n_fs;
      pix(1'b1, 1'b1, 12'h055);
      pix(1'b0, 1'b1, 12'h056);
      pix(1'b0, 1'b1, 12'h057);
      pix(1'b0, 1'b1, 12'h058);
      pix(1'b0, 1'b0, '0);
      pix(1'b0, 1'b0, '0);
      check("t4_fs", 32'(n_fs - fs0), 32'd1);
      check("t4_no_pv", 32'(n_pv - pv0), 32'd0);
      line(5, 0, 200, 1'b1);
      check("t4_pv", 32'(n_pv - pv0), 32'd5);

      // ---- 1100-pixel line saturates x
      vsync_pulse();
      lm0 = n_lm;
      line(1100, 0, 0, 1'b1);
      check("t5_x_sat",    32'(pix_if.pixel_x), 32'd1023);
      check("t5_y",        32'(pix_if.pixel_y), 32'd0);
      check("t5_overflow", 32'(pix_if.overflow), 32'd1);
`ifdef PI_DPI_CAPTURE_LINE_STATS_EN
      check("t5_line_len", 32'(pix_if.line_length), 32'd1100);
      check("t5_mismatch", 32'(n_lm - lm0), 32'd1);
`else
      check("t5_line_len", 32'(pix_if.line_length), 32'd0);
      check("t5_mismatch", 32'(n_lm - lm0), 32'd0);
`endif

      // ---- reset in the middle of a line at x=300
      vsync_pulse();
      for (int i = 0; i <= 300; i++) begin
         exp_q.push_back('{i, 0, (i + 40) & 'hfff, (i == 0)});
         pix(1'b0, 1'b1, DATA_W'(i + 40));
      end
      check("t6_x_before", 32'(pix_if.pixel_x), 32'd300);
      tick();
      dpi_data = DATA_W'(341);
      reset = 1'b1;
      tick();
      check_reset_values("t6_reset");
      repeat (4) tick();
      reset = 1'b0;
      pv0 = n_pv; fs0 = n_fs;
      for (int i = 0; i < 10; i++) pix(1'b0, 1'b1, DATA_W'(i));
      pix(1'b0, 1'b0, '0);
      line(10, 0, 0, 1'b0);
      check("t6_no_pv", 32'(n_pv - pv0), 32'd0);
      vsync_pulse();
      line(3, 0, 500, 1'b1);
      check("t6_pv_after_vsync", 32'(n_pv - pv0), 32'd3);
      check("t6_fs", 32'(n_fs - fs0), 32'd1);

      // ---- global
      check("phase_alignment", 32'(n_phase_bad), 32'd0);
      check("final_queue", 32'(exp_q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
